// File: rtl/axi_lite_slave_decoupler.sv
// AXI4-Lite slave-side decoupler: bounds outstanding requests and isolates
// the downstream slave on request, synthesising SLVERR replies when forced.
module axi_lite_slave_decoupler #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int OUTSTANDING_WREQ = 8,
  parameter int OUTSTANDING_RREQ = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,

  input  logic [AXI_ADDR_WIDTH-1:0]     axi_lite_s_awaddr,
  input  logic                          axi_lite_s_awvalid,
  output logic                          axi_lite_s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_lite_s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   axi_lite_s_wstrb,
  input  logic                          axi_lite_s_wvalid,
  output logic                          axi_lite_s_wready,
  output logic [1:0]                    axi_lite_s_bresp,
  output logic                          axi_lite_s_bvalid,
  input  logic                          axi_lite_s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_lite_s_araddr,
  input  logic                          axi_lite_s_arvalid,
  output logic                          axi_lite_s_arready,
  output logic [AXI_DATA_WIDTH-1:0]     axi_lite_s_rdata,
  output logic [1:0]                    axi_lite_s_rresp,
  output logic                          axi_lite_s_rvalid,
  input  logic                          axi_lite_s_rready,

  output logic [AXI_ADDR_WIDTH-1:0]     axi_lite_m_awaddr,
  output logic                          axi_lite_m_awvalid,
  input  logic                          axi_lite_m_awready,
  output logic [AXI_DATA_WIDTH-1:0]     axi_lite_m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   axi_lite_m_wstrb,
  output logic                          axi_lite_m_wvalid,
  input  logic                          axi_lite_m_wready,
  input  logic [1:0]                    axi_lite_m_bresp,
  input  logic                          axi_lite_m_bvalid,
  output logic                          axi_lite_m_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     axi_lite_m_araddr,
  output logic                          axi_lite_m_arvalid,
  input  logic                          axi_lite_m_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_lite_m_rdata,
  input  logic [1:0]                    axi_lite_m_rresp,
  input  logic                          axi_lite_m_rvalid,
  output logic                          axi_lite_m_rready,

  input  logic                          decouple,
  input  logic                          decouple_force,
  output logic                          decouple_done,
  output logic                          bresp_expected,
  output logic                          rresp_expected
);

  localparam int WCW = $clog2(OUTSTANDING_WREQ + 1);
  localparam int RCW = $clog2(OUTSTANDING_RREQ + 1);

  localparam logic [WCW-1:0] W_MAX = WCW'(OUTSTANDING_WREQ);
  localparam logic [RCW-1:0] R_MAX = RCW'(OUTSTANDING_RREQ);
  localparam logic [WCW-1:0] W_ONE = WCW'(1);
  localparam logic [RCW-1:0] R_ONE = RCW'(1);
  localparam logic [1:0]     SLVERR = 2'b10;

  logic [WCW-1:0] aw_cnt_q, aw_cnt_d;
  logic [WCW-1:0] w_cnt_q, w_cnt_d;
  logic [RCW-1:0] ar_cnt_q, ar_cnt_d;

  logic iso, frc;
  logic aw_ok, w_ok, ar_ok;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign frc = decouple_force;
  assign iso = decouple | decouple_force;

  // While isolated only the lagging half of a write may advance.
  always_comb begin
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    ar_ok = 1'b0;
    if (iso) begin
      aw_ok = aw_cnt_q < w_cnt_q;
      w_ok  = w_cnt_q < aw_cnt_q;
    end else begin
      aw_ok = aw_cnt_q != W_MAX;
      w_ok  = w_cnt_q != W_MAX;
      ar_ok = ar_cnt_q != R_MAX;
    end
  end

  assign axi_lite_m_awaddr  = axi_lite_s_awaddr;
  assign axi_lite_m_awvalid = axi_lite_s_awvalid & aw_ok & ~frc;
  assign axi_lite_s_awready = aw_ok & (frc | axi_lite_m_awready);

  assign axi_lite_m_wdata   = axi_lite_s_wdata;
  assign axi_lite_m_wstrb   = axi_lite_s_wstrb;
  assign axi_lite_m_wvalid  = axi_lite_s_wvalid & w_ok & ~frc;
  assign axi_lite_s_wready  = w_ok & (frc | axi_lite_m_wready);

  assign axi_lite_m_araddr  = axi_lite_s_araddr;
  assign axi_lite_m_arvalid = axi_lite_s_arvalid & ar_ok & ~frc;
  assign axi_lite_s_arready = ar_ok & axi_lite_m_arready;

  assign bresp_expected = (aw_cnt_q != '0) && (w_cnt_q != '0);
  assign rresp_expected = ar_cnt_q != '0;

  // Forced mode answers owed responses locally with SLVERR.
  assign axi_lite_s_bvalid = frc ? bresp_expected : axi_lite_m_bvalid;
  assign axi_lite_s_bresp  = frc ? SLVERR : axi_lite_m_bresp;
  assign axi_lite_m_bready = axi_lite_s_bready & ~frc;

  assign axi_lite_s_rvalid = frc ? rresp_expected : axi_lite_m_rvalid;
  assign axi_lite_s_rresp  = frc ? SLVERR : axi_lite_m_rresp;
  assign axi_lite_s_rdata  = frc ? '0 : axi_lite_m_rdata;
  assign axi_lite_m_rready = axi_lite_s_rready & ~frc;

  assign aw_hs = axi_lite_s_awvalid & axi_lite_s_awready;
  assign w_hs  = axi_lite_s_wvalid & axi_lite_s_wready;
  assign ar_hs = axi_lite_s_arvalid & axi_lite_s_arready;
  assign b_hs  = axi_lite_s_bvalid & axi_lite_s_bready;
  assign r_hs  = axi_lite_s_rvalid & axi_lite_s_rready;

  assign decouple_done = iso && (aw_cnt_q == '0) &&
                         (w_cnt_q == '0) && (ar_cnt_q == '0);

  always_comb begin
    aw_cnt_d = aw_cnt_q;
    unique case ({aw_hs, b_hs})
      2'b10:   aw_cnt_d = aw_cnt_q + W_ONE;
      2'b01:   aw_cnt_d = aw_cnt_q - W_ONE;
      default: aw_cnt_d = aw_cnt_q;
    endcase
  end

  always_comb begin
    w_cnt_d = w_cnt_q;
    unique case ({w_hs, b_hs})
      2'b10:   w_cnt_d = w_cnt_q + W_ONE;
      2'b01:   w_cnt_d = w_cnt_q - W_ONE;
      default: w_cnt_d = w_cnt_q;
    endcase
  end

  always_comb begin
    ar_cnt_d = ar_cnt_q;
    unique case ({ar_hs, r_hs})
      2'b10:   ar_cnt_d = ar_cnt_q + R_ONE;
      2'b01:   ar_cnt_d = ar_cnt_q - R_ONE;
      default: ar_cnt_d = ar_cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt_q <= '0;
      w_cnt_q  <= '0;
      ar_cnt_q <= '0;
    end else begin
      aw_cnt_q <= aw_cnt_d;
      w_cnt_q  <= w_cnt_d;
      ar_cnt_q <= ar_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_decoupler.sv
// Randomised and directed bench for axi_lite_slave_decoupler against a
// count-based reference model of the isolation rules.
module tb_axi_lite_slave_decoupler;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int OR = 8;

  logic aclk = 1'b0;
  logic aresetn;

  logic [AW-1:0]   axi_lite_s_awaddr;
  logic            axi_lite_s_awvalid;
  logic            axi_lite_s_awready;
  logic [DW-1:0]   axi_lite_s_wdata;
  logic [DW/8-1:0] axi_lite_s_wstrb;
  logic            axi_lite_s_wvalid;
  logic            axi_lite_s_wready;
  logic [1:0]      axi_lite_s_bresp;
  logic            axi_lite_s_bvalid;
  logic            axi_lite_s_bready;
  logic [AW-1:0]   axi_lite_s_araddr;
  logic            axi_lite_s_arvalid;
  logic            axi_lite_s_arready;
  logic [DW-1:0]   axi_lite_s_rdata;
  logic [1:0]      axi_lite_s_rresp;
  logic            axi_lite_s_rvalid;
  logic            axi_lite_s_rready;

  logic [AW-1:0]   axi_lite_m_awaddr;
  logic            axi_lite_m_awvalid;
  logic            axi_lite_m_awready;
  logic [DW-1:0]   axi_lite_m_wdata;
  logic [DW/8-1:0] axi_lite_m_wstrb;
  logic            axi_lite_m_wvalid;
  logic            axi_lite_m_wready;
  logic [1:0]      axi_lite_m_bresp;
  logic            axi_lite_m_bvalid;
  logic            axi_lite_m_bready;
  logic [AW-1:0]   axi_lite_m_araddr;
  logic            axi_lite_m_arvalid;
  logic            axi_lite_m_arready;
  logic [DW-1:0]   axi_lite_m_rdata;
  logic [1:0]      axi_lite_m_rresp;
  logic            axi_lite_m_rvalid;
  logic            axi_lite_m_rready;

  logic decouple, decouple_force;
  logic decouple_done, bresp_expected, rresp_expected;

  axi_lite_slave_decoupler #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .OUTSTANDING_WREQ(OW),
    .OUTSTANDING_RREQ(OR)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .axi_lite_s_awaddr(axi_lite_s_awaddr),
    .axi_lite_s_awvalid(axi_lite_s_awvalid),
    .axi_lite_s_awready(axi_lite_s_awready),
    .axi_lite_s_wdata(axi_lite_s_wdata),
    .axi_lite_s_wstrb(axi_lite_s_wstrb),
    .axi_lite_s_wvalid(axi_lite_s_wvalid),
    .axi_lite_s_wready(axi_lite_s_wready),
    .axi_lite_s_bresp(axi_lite_s_bresp),
    .axi_lite_s_bvalid(axi_lite_s_bvalid),
    .axi_lite_s_bready(axi_lite_s_bready),
    .axi_lite_s_araddr(axi_lite_s_araddr),
    .axi_lite_s_arvalid(axi_lite_s_arvalid),
    .axi_lite_s_arready(axi_lite_s_arready),
    .axi_lite_s_rdata(axi_lite_s_rdata),
    .axi_lite_s_rresp(axi_lite_s_rresp),
    .axi_lite_s_rvalid(axi_lite_s_rvalid),
    .axi_lite_s_rready(axi_lite_s_rready),
    .axi_lite_m_awaddr(axi_lite_m_awaddr),
    .axi_lite_m_awvalid(axi_lite_m_awvalid),
    .axi_lite_m_awready(axi_lite_m_awready),
    .axi_lite_m_wdata(axi_lite_m_wdata),
    .axi_lite_m_wstrb(axi_lite_m_wstrb),
    .axi_lite_m_wvalid(axi_lite_m_wvalid),
    .axi_lite_m_wready(axi_lite_m_wready),
    .axi_lite_m_bresp(axi_lite_m_bresp),
    .axi_lite_m_bvalid(axi_lite_m_bvalid),
    .axi_lite_m_bready(axi_lite_m_bready),
    .axi_lite_m_araddr(axi_lite_m_araddr),
    .axi_lite_m_arvalid(axi_lite_m_arvalid),
    .axi_lite_m_arready(axi_lite_m_arready),
    .axi_lite_m_rdata(axi_lite_m_rdata),
    .axi_lite_m_rresp(axi_lite_m_rresp),
    .axi_lite_m_rvalid(axi_lite_m_rvalid),
    .axi_lite_m_rready(axi_lite_m_rready),
    .decouple(decouple),
    .decouple_force(decouple_force),
    .decouple_done(decouple_done),
    .bresp_expected(bresp_expected),
    .rresp_expected(rresp_expected)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;
  int aw_n = 0;
  int w_n = 0;
  int ar_n = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    axi_lite_s_awaddr  = $urandom;
    axi_lite_s_awvalid = 1'b0;
    axi_lite_s_wdata   = $urandom;
    axi_lite_s_wstrb   = 4'($urandom);
    axi_lite_s_wvalid  = 1'b0;
    axi_lite_s_bready  = 1'b1;
    axi_lite_s_araddr  = $urandom;
    axi_lite_s_arvalid = 1'b0;
    axi_lite_s_rready  = 1'b1;
    axi_lite_m_awready = 1'b1;
    axi_lite_m_wready  = 1'b1;
    axi_lite_m_bresp   = 2'($urandom);
    axi_lite_m_bvalid  = 1'b0;
    axi_lite_m_arready = 1'b1;
    axi_lite_m_rdata   = $urandom;
    axi_lite_m_rresp   = 2'($urandom);
    axi_lite_m_rvalid  = 1'b0;
    decouple           = 1'b0;
    decouple_force     = 1'b0;
  endtask

  // Called just after a falling edge; checks every output against the
  // model, then advances the model across the next rising edge.
  task automatic step();
    bit frc, iso, aw_ok, w_ok, ar_ok;
    bit e_awr, e_wr, e_arr, e_bv, e_rv, e_done;
    bit awhs, whs, arhs, bhs, rhs;
    logic [1:0] e_br, e_rr;
    logic [DW-1:0] e_rd;
    #2;
    frc = decouple_force;
    iso = decouple || decouple_force;
    aw_ok = iso ? (aw_n < w_n) : (aw_n < OW);
    w_ok  = iso ? (w_n < aw_n) : (w_n < OW);
    ar_ok = !iso && (ar_n < OR);
    e_awr = aw_ok && (frc || axi_lite_m_awready);
    e_wr  = w_ok && (frc || axi_lite_m_wready);
    e_arr = ar_ok && axi_lite_m_arready;
    e_bv  = frc ? (aw_n > 0 && w_n > 0) : axi_lite_m_bvalid;
    e_br  = frc ? 2'b10 : axi_lite_m_bresp;
    e_rv  = frc ? (ar_n > 0) : axi_lite_m_rvalid;
    e_rr  = frc ? 2'b10 : axi_lite_m_rresp;
    e_rd  = frc ? '0 : axi_lite_m_rdata;
    e_done = iso && aw_n == 0 && w_n == 0 && ar_n == 0;
    chk("s_awready", axi_lite_s_awready, e_awr);
    chk("s_wready", axi_lite_s_wready, e_wr);
    chk("s_arready", axi_lite_s_arready, e_arr);
    chk("m_awvalid", axi_lite_m_awvalid,
        axi_lite_s_awvalid && aw_ok && !frc);
    chk("m_wvalid", axi_lite_m_wvalid,
        axi_lite_s_wvalid && w_ok && !frc);
    chk("m_arvalid", axi_lite_m_arvalid,
        axi_lite_s_arvalid && ar_ok && !frc);
    chk("m_awaddr", axi_lite_m_awaddr, axi_lite_s_awaddr);
    chk("m_wdata", axi_lite_m_wdata, axi_lite_s_wdata);
    chk("m_wstrb", axi_lite_m_wstrb, axi_lite_s_wstrb);
    chk("m_araddr", axi_lite_m_araddr, axi_lite_s_araddr);
    chk("s_bvalid", axi_lite_s_bvalid, e_bv);
    chk("s_bresp", axi_lite_s_bresp, e_br);
    chk("s_rvalid", axi_lite_s_rvalid, e_rv);
    chk("s_rresp", axi_lite_s_rresp, e_rr);
    chk("s_rdata", axi_lite_s_rdata, e_rd);
    chk("m_bready", axi_lite_m_bready, axi_lite_s_bready && !frc);
    chk("m_rready", axi_lite_m_rready, axi_lite_s_rready && !frc);
    chk("bresp_exp", bresp_expected, aw_n > 0 && w_n > 0);
    chk("rresp_exp", rresp_expected, ar_n > 0);
    chk("done", decouple_done, e_done);
    awhs = axi_lite_s_awvalid && e_awr;
    whs  = axi_lite_s_wvalid && e_wr;
    arhs = axi_lite_s_arvalid && e_arr;
    bhs  = e_bv && axi_lite_s_bready;
    rhs  = e_rv && axi_lite_s_rready;
    @(posedge aclk);
    if (aresetn) begin
      aw_n = aw_n + int'(awhs) - int'(bhs);
      w_n  = w_n + int'(whs) - int'(bhs);
      ar_n = ar_n + int'(arhs) - int'(rhs);
    end
    @(negedge aclk);
  endtask

  task automatic rand_cycle(input int mode);
    axi_lite_s_awaddr  = $urandom;
    axi_lite_s_wdata   = $urandom;
    axi_lite_s_wstrb   = 4'($urandom);
    axi_lite_s_araddr  = $urandom;
    axi_lite_s_awvalid = ($urandom_range(0, 9) < 7);
    axi_lite_s_wvalid  = ($urandom_range(0, 9) < 7);
    axi_lite_s_arvalid = ($urandom_range(0, 9) < 7);
    axi_lite_s_bready  = ($urandom_range(0, 9) < 6);
    axi_lite_s_rready  = ($urandom_range(0, 9) < 6);
    axi_lite_m_awready = ($urandom_range(0, 9) < 7);
    axi_lite_m_wready  = ($urandom_range(0, 9) < 7);
    axi_lite_m_arready = ($urandom_range(0, 9) < 7);
    axi_lite_m_bresp   = 2'($urandom);
    axi_lite_m_rresp   = 2'($urandom);
    axi_lite_m_rdata   = $urandom;
    axi_lite_m_bvalid  = ($urandom_range(0, 9) < 3) && aw_n > 0 && w_n > 0;
    axi_lite_m_rvalid  = ($urandom_range(0, 9) < 3) && ar_n > 0;
    decouple           = (mode == 1) || (mode == 3 && $urandom_range(0, 1) == 1);
    decouple_force     = (mode == 2);
  endtask

  initial begin
    idle();
    aresetn = 1'b0;
    #1;
    chk("rst_bexp", bresp_expected, 1'b0);
    chk("rst_rexp", rresp_expected, 1'b0);
    chk("rst_done", decouple_done, 1'b0);
    @(negedge aclk);
    step();
    aresetn = 1'b1;
    step();

    // Fill the write window while the slave withholds B.
    idle();
    for (int i = 0; i < OW; i++) begin
      axi_lite_s_awvalid = 1'b1;
      axi_lite_s_wvalid  = 1'b1;
      step();
    end
    axi_lite_s_wvalid = 1'b0;
    #1;
    chk("aw_full_rdy", axi_lite_s_awready, 1'b0);
    chk("aw_full_bexp", bresp_expected, 1'b1);
    step();
    axi_lite_s_awvalid = 1'b0;
    axi_lite_m_bvalid  = 1'b1;
    for (int i = 0; i < OW; i++) step();
    axi_lite_m_bvalid = 1'b0;
    #1;
    chk("aw_drain_bexp", bresp_expected, 1'b0);
    step();

    // Graceful decouple lets a half-issued write complete.
    idle();
    axi_lite_s_awvalid = 1'b1;
    step();
    axi_lite_s_awvalid = 1'b0;
    decouple = 1'b1;
    axi_lite_s_wvalid = 1'b1;
    #1;
    chk("iso_w_pass", axi_lite_s_wready, 1'b1);
    step();
    axi_lite_s_wvalid = 1'b0;
    axi_lite_m_bvalid = 1'b1;
    #1;
    chk("iso_done_pre", decouple_done, 1'b0);
    step();
    axi_lite_m_bvalid  = 1'b0;
    axi_lite_s_arvalid = 1'b1;
    #1;
    chk("iso_done", decouple_done, 1'b1);
    chk("iso_ar_block", axi_lite_s_arready, 1'b0);
    step();

    // Forced isolation answers three owed reads locally.
    idle();
    axi_lite_s_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    axi_lite_s_arvalid = 1'b0;
    decouple_force     = 1'b1;
    axi_lite_m_rvalid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frc_rvalid", axi_lite_s_rvalid, 1'b1);
      chk("frc_rresp", axi_lite_s_rresp, 2'b10);
      chk("frc_rdata", axi_lite_s_rdata, '0);
      chk("frc_mrready", axi_lite_m_rready, 1'b0);
      step();
    end
    axi_lite_m_rvalid = 1'b0;
    #1;
    chk("frc_done", decouple_done, 1'b1);
    step();

    // AW and B in the same cycle at aw_cnt=2.
    idle();
    axi_lite_s_awvalid = 1'b1;
    axi_lite_s_wvalid  = 1'b1;
    step();
    step();
    axi_lite_s_wvalid = 1'b0;
    axi_lite_m_bvalid = 1'b1;
    step();
    axi_lite_s_awvalid = 1'b0;
    axi_lite_m_bvalid  = 1'b0;
    axi_lite_s_wvalid  = 1'b1;
    step();
    axi_lite_s_wvalid = 1'b0;
    axi_lite_m_bvalid = 1'b1;
    step();
    #1;
    chk("awb_one_left", bresp_expected, 1'b1);
    step();
    axi_lite_m_bvalid = 1'b0;
    #1;
    chk("awb_empty", bresp_expected, 1'b0);
    step();

    // Asynchronous reset in the middle of a read burst.
    idle();
    axi_lite_s_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #1;
    chk("pre_rst_rexp", rresp_expected, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("async_rst_rexp", rresp_expected, 1'b0);
    aw_n = 0;
    w_n  = 0;
    ar_n = 0;
    @(negedge aclk);
    step();
    aresetn = 1'b1;
    step();

    for (int c = 0; c < 60; c++) begin
      int mode;
      int r;
      r = $urandom_range(0, 99);
      mode = (r < 50) ? 0 : (r < 70) ? 1 : (r < 85) ? 2 : 3;
      if ($urandom_range(0, 19) == 0) begin
        idle();
        aresetn = 1'b0;
        aw_n = 0;
        w_n  = 0;
        ar_n = 0;
        step();
        aresetn = 1'b1;
      end
      for (int k = 0; k < 40; k++) begin
        rand_cycle(mode);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
